multiplication_float16: RTL



---
 rtl/fp16_pkg.sv | 39 +++
 rtl/fp16_norm_round.sv | 62 ++++++
 rtl/multiplication_float16.sv | 136 +++++++++++++
 3 files changed

// File: rtl/fp16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp16_pkg
// Description : Shared IEEE-754 half-precision constants, operand classes and
//               a classification helper for the float16 arithmetic blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package fp16_pkg;

    localparam int          FP16_BIAS    = 15;
    localparam int          FP16_EXP_MAX = 31;
    localparam logic [15:0] FP16_QNAN    = 16'h7E00;
    localparam int          EXP_W        = 5;
    localparam int          FRAC_W       = 10;

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        NORM = 2'd1,
        INF  = 2'd2,
        NAN  = 2'd3
    } fp16_class_t;

    // Subnormal encodings fall into ZERO: the datapath flushes them.
    function automatic fp16_class_t fp16_classify(input logic [15:0] v);
        logic [EXP_W-1:0]  ex;
        logic [FRAC_W-1:0] fr;
        ex = v[14:10];
        fr = v[9:0];
        if (ex == '0) begin
            return ZERO;
        end else if (ex == EXP_W'(FP16_EXP_MAX)) begin
            return (fr == '0) ? INF : NAN;
        end else begin
            return NORM;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp16_norm_round.sv
`default_nettype none
// ============================================================================
// Module      : fp16_norm_round
// Description : Combinational normalise / round / pack of a 22-bit mantissa
//               product. MULTIPLICATION_FLOAT16_RNE_EN selects round-to-
//               nearest-even; otherwise the product is truncated.
// Revision    : 1.0 - initial release
// ============================================================================
module fp16_norm_round
    import fp16_pkg::*;
(
    input  logic        [21:0] p,
    input  logic signed [6:0]  e,
    input  logic               sign,
    output logic        [15:0] result
);

    localparam logic signed [7:0] c_exp_max = 8'(FP16_EXP_MAX);

    logic                     w_hi;
    logic [FRAC_W-1:0]        w_mant;
    logic signed [7:0]        w_e_norm;
    logic [FRAC_W-1:0]        w_mant_rnd;
    logic signed [7:0]        w_e_rnd;

    assign w_hi     = p[21];
    assign w_mant   = w_hi ? p[20:11] : p[19:10];
    assign w_e_norm = {e[6], e} + {7'd0, w_hi};

`ifdef MULTIPLICATION_FLOAT16_RNE_EN
    logic              w_guard;
    logic              w_sticky;
    logic              w_inc;
    logic [FRAC_W:0]   w_sum;

    assign w_guard    = w_hi ? p[10] : p[9];
    assign w_sticky   = w_hi ? (|p[9:0]) : (|p[8:0]);
    assign w_inc      = w_guard & (w_sticky | w_mant[0]);
    assign w_sum      = {1'b0, w_mant} + {{FRAC_W{1'b0}}, w_inc};
    // A carry out leaves the fraction at zero and bumps the exponent.
    assign w_mant_rnd = w_sum[FRAC_W-1:0];
    assign w_e_rnd    = w_e_norm + {7'd0, w_sum[FRAC_W]};
`else
    logic w_unused_lsbs;

    assign w_unused_lsbs = ^p[9:0];
    assign w_mant_rnd    = w_mant;
    assign w_e_rnd       = w_e_norm;
`endif

    always_comb begin
        if (w_e_rnd >= c_exp_max) begin
            result = {sign, 5'h1F, 10'h000};
        end else if (w_e_rnd <= 8'sd0) begin
            result = {sign, 15'h0000};
        end else begin
            result = {sign, w_e_rnd[EXP_W-1:0], w_mant_rnd};
        end
    end

endmodule
`default_nettype wire

// File: rtl/multiplication_float16.sv
`default_nettype none
// ============================================================================
// Module      : multiplication_float16
// Description : Three-stage pipelined float16 multiplier with valid/ready
//               handshake and whole-pipe stall. Rounding mode is selected by
//               MULTIPLICATION_FLOAT16_RNE_EN (defined: RNE, else truncate).
// Revision    : 1.0 - initial release
// ============================================================================
module multiplication_float16
    import fp16_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int LATENCY    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [DATA_WIDTH-1:0] multiplicand,
    input  logic [DATA_WIDTH-1:0] multiplier,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [DATA_WIDTH-1:0] result
);

    generate
        if (DATA_WIDTH != 16 || LATENCY != 3) begin : g_bad_param
            $error("multiplication_float16 supports only DATA_WIDTH=16, LATENCY=3");
        end
    endgenerate

    // ---------------- handshake ----------------
    logic w_advance;

    assign w_advance = ~out_vld | out_rdy;
    assign in_rdy    = w_advance;

    // ---------------- S1 decode ----------------
    fp16_class_t       w_cls_a;
    fp16_class_t       w_cls_b;
    logic              w_sign;
    logic              w_nan;
    logic              w_special;
    logic [15:0]       w_spec_val;
    logic signed [6:0] w_e_sum;

    assign w_cls_a = fp16_classify(multiplicand);
    assign w_cls_b = fp16_classify(multiplier);
    assign w_sign  = multiplicand[15] ^ multiplier[15];

    assign w_nan = (w_cls_a == NAN) || (w_cls_b == NAN) ||
                   (w_cls_a == INF && w_cls_b == ZERO) ||
                   (w_cls_a == ZERO && w_cls_b == INF);
    assign w_special = (w_cls_a != NORM) || (w_cls_b != NORM);

    always_comb begin
        if (w_nan) begin
            w_spec_val = FP16_QNAN;
        end else if (w_cls_a == INF || w_cls_b == INF) begin
            w_spec_val = {w_sign, 5'h1F, 10'h000};
        end else begin
            w_spec_val = {w_sign, 15'h0000};
        end
    end

    assign w_e_sum = $signed({2'b00, multiplicand[14:10]})
                   + $signed({2'b00, multiplier[14:10]})
                   - 7'(FP16_BIAS);

    // ---------------- stage registers ----------------
    logic              r_s1_vld;
    logic              r_s1_special;
    logic [15:0]       r_s1_spec_val;
    logic              r_s1_sign;
    logic [FRAC_W:0]   r_s1_ma;
    logic [FRAC_W:0]   r_s1_mb;
    logic signed [6:0] r_s1_e;

    logic              r_s2_vld;
    logic              r_s2_special;
    logic [15:0]       r_s2_spec_val;
    logic              r_s2_sign;
    logic [21:0]       r_s2_p;
    logic signed [6:0] r_s2_e;

    logic              r_out_vld;
    logic [15:0]       r_result;
    logic [15:0]       w_norm_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld  <= 1'b0;
            r_s2_vld  <= 1'b0;
            r_out_vld <= 1'b0;
            r_result  <= '0;
        end else if (w_advance) begin
            r_s1_vld  <= in_vld;
            r_s2_vld  <= r_s1_vld;
            r_out_vld <= r_s2_vld;
            // Bubbles leave the last result on the bus untouched.
            if (r_s2_vld) begin
                r_result <= r_s2_special ? r_s2_spec_val : w_norm_result;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_advance) begin
            r_s1_special  <= w_special;
            r_s1_spec_val <= w_spec_val;
            r_s1_sign     <= w_sign;
            r_s1_ma       <= {1'b1, multiplicand[FRAC_W-1:0]};
            r_s1_mb       <= {1'b1, multiplier[FRAC_W-1:0]};
            r_s1_e        <= w_e_sum;

            r_s2_special  <= r_s1_special;
            r_s2_spec_val <= r_s1_spec_val;
            r_s2_sign     <= r_s1_sign;
            r_s2_p        <= {11'd0, r_s1_ma} * {11'd0, r_s1_mb};
            r_s2_e        <= r_s1_e;
        end
    end

    // ---------------- S3 normalise / round / pack ----------------
    fp16_norm_round u_norm_round (
        .p      (r_s2_p),
        .e      (r_s2_e),
        .sign   (r_s2_sign),
        .result (w_norm_result)
    );

    assign out_vld = r_out_vld;
    assign result  = r_result;

endmodule
`default_nettype wire
